// File: rtl/aurora_hls_nfc_pkg.sv
// Shared definitions for the Aurora RX native-flow-control controller.
//   - nfc_state_e : controller FSM state encoding
//   - NFC_XOFF / NFC_XON : fixed NFC words for XOFF/XON operation
//   - sat_inc()   : saturating increment at an arbitrary width (up to 64 bits)
package aurora_hls_nfc_pkg;

  typedef enum logic [2:0] {
    ST_RUN          = 3'd0,
    ST_SEND_PAUSE   = 3'd1,
    ST_PAUSED       = 3'd2,
    ST_SEND_REFRESH = 3'd3,
    ST_SEND_XON     = 3'd4
  } nfc_state_e;

  localparam logic [15:0] NFC_XOFF = 16'hFFFF;
  localparam logic [15:0] NFC_XON  = 16'h0000;

  // Increment value by one unless it already holds the all-ones value of a
  // width-bit counter; callers zero-extend into and truncate out of 64 bits.
  function automatic logic [63:0] sat_inc(input logic [63:0] value,
                                          input int unsigned width);
    logic [63:0] max_value;
    max_value = (width >= 64) ? {64{1'b1}} : ((64'd1 << width) - 64'd1);
    return (value >= max_value) ? value : value + 64'd1;
  endfunction

endpackage

// File: rtl/aurora_hls_sat_counter.sv
// Saturating statistics counter.
//   clk, rst : clock, asynchronous active-high reset
//   inc      : add one this cycle (holds at all-ones)
//   clr      : synchronous clear, wins over inc
//   count    : registered count value
module aurora_hls_sat_counter
  import aurora_hls_nfc_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH = 32
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   inc,
  input  logic                   clr,
  output logic [COUNT_WIDTH-1:0] count
);

  logic [COUNT_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (inc) begin
      count_d = COUNT_WIDTH'(sat_inc(64'(count_q), COUNT_WIDTH));
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/aurora_hls_nfc_ctrl.sv
// Native-flow-control controller for the Aurora RX path.
// Watches the RX FIFO thresholds and offers pause (XOFF or timed-pause) and
// XON words on the core's s_axi_nfc stream, with optional periodic pause
// refresh and saturating statistics.
//   clk, rst               : clock, asynchronous active-high reset
//   enable                 : permits new pause requests; low while paused forces XON
//   clear_counters         : synchronous clear of all statistics
//   fifo_rx_prog_full/empty: RX FIFO high/low threshold flags
//   rx_tvalid              : RX beat arriving, counted while paused
//   s_axi_nfc_*            : NFC request stream (tdata big-endian [0:15])
//   *_count, latency_max   : statistics, saturating at all-ones
module aurora_hls_nfc_ctrl
  import aurora_hls_nfc_pkg::*;
#(
  parameter int unsigned COUNT_WIDTH    = 32,
  parameter int unsigned PAUSE_MODE     = 0,
  parameter logic [15:0] PAUSE_VALUE    = 16'h00FF,
  parameter int unsigned REFRESH_CYCLES = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  input  logic                   clear_counters,
  input  logic                   fifo_rx_prog_full,
  input  logic                   fifo_rx_prog_empty,
  input  logic                   rx_tvalid,
  input  logic                   s_axi_nfc_tready,
  output logic                   s_axi_nfc_tvalid,
  output logic [0:15]            s_axi_nfc_tdata,
  output logic [COUNT_WIDTH-1:0] full_trigger_count,
  output logic [COUNT_WIDTH-1:0] empty_trigger_count,
  output logic [COUNT_WIDTH-1:0] refresh_count,
  output logic [COUNT_WIDTH-1:0] latency_count,
  output logic [COUNT_WIDTH-1:0] latency_max
);

  localparam logic [15:0] PAUSE_WORD   = (PAUSE_MODE == 1) ? PAUSE_VALUE : NFC_XOFF;
  localparam logic [31:0] REFRESH_LAST = (REFRESH_CYCLES == 0) ? 32'd0
                                                              : 32'(REFRESH_CYCLES - 1);

  nfc_state_e             state_q, state_d;
  logic                   tvalid_q, tvalid_d;
  logic [0:15]            tdata_q, tdata_d;
  logic [31:0]            timer_q, timer_d;
  logic [COUNT_WIDTH-1:0] latency_max_q, latency_max_d;

  logic handshake;
  logic full_inc, empty_inc, refresh_inc, lat_inc, lat_zero;

  assign handshake = tvalid_q && s_axi_nfc_tready;

  // NOTE: every variable assigned below gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d     = state_q;
    tvalid_d    = tvalid_q;
    tdata_d     = tdata_q;
    timer_d     = timer_q;
    full_inc    = 1'b0;
    empty_inc   = 1'b0;
    refresh_inc = 1'b0;
    lat_inc     = 1'b0;
    lat_zero    = 1'b0;

    unique case (state_q)
      ST_RUN: begin
        if (enable && fifo_rx_prog_full) begin
          state_d  = ST_SEND_PAUSE;
          tvalid_d = 1'b1;
          tdata_d  = PAUSE_WORD;
        end
      end

      // Once offered, the pause word stays up until accepted.
      ST_SEND_PAUSE: begin
        if (handshake) begin
          state_d  = ST_PAUSED;
          tvalid_d = 1'b0;
          full_inc = 1'b1;
          lat_zero = 1'b1;
          timer_d  = '0;
        end
      end

      // XON is checked before refresh so a draining FIFO never gets re-paused.
      ST_PAUSED: begin
        lat_inc = rx_tvalid;
        if (fifo_rx_prog_empty || !enable) begin
          state_d  = ST_SEND_XON;
          tvalid_d = 1'b1;
          tdata_d  = NFC_XON;
        end else if (REFRESH_CYCLES != 0 && timer_q == REFRESH_LAST) begin
          state_d  = ST_SEND_REFRESH;
          tvalid_d = 1'b1;
          tdata_d  = PAUSE_WORD;
        end else begin
          timer_d = timer_q + 32'd1;
        end
      end

      ST_SEND_REFRESH: begin
        lat_inc = rx_tvalid;
        if (handshake) begin
          state_d     = ST_PAUSED;
          tvalid_d    = 1'b0;
          refresh_inc = 1'b1;
          timer_d     = '0;
        end
      end

      ST_SEND_XON: begin
        if (handshake) begin
          state_d   = ST_RUN;
          tvalid_d  = 1'b0;
          empty_inc = 1'b1;
        end
      end

      default: begin
        state_d  = ST_RUN;
        tvalid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_RUN;
      tvalid_q <= 1'b0;
      tdata_q  <= NFC_XON;
      timer_q  <= '0;
    end else begin
      state_q  <= state_d;
      tvalid_q <= tvalid_d;
      tdata_q  <= tdata_d;
      timer_q  <= timer_d;
    end
  end

  assign s_axi_nfc_tvalid = tvalid_q;
  assign s_axi_nfc_tdata  = tdata_q;

  aurora_hls_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_full_cnt (
    .clk(clk), .rst(rst), .inc(full_inc), .clr(clear_counters),
    .count(full_trigger_count)
  );

  aurora_hls_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_empty_cnt (
    .clk(clk), .rst(rst), .inc(empty_inc), .clr(clear_counters),
    .count(empty_trigger_count)
  );

  aurora_hls_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_refresh_cnt (
    .clk(clk), .rst(rst), .inc(refresh_inc), .clr(clear_counters),
    .count(refresh_count)
  );

  // Latency restarts from zero each time an initial pause is accepted.
  aurora_hls_sat_counter #(.COUNT_WIDTH(COUNT_WIDTH)) u_latency_cnt (
    .clk(clk), .rst(rst), .inc(lat_inc), .clr(clear_counters || lat_zero),
    .count(latency_count)
  );

  // Tracks the registered latency_count, so it trails it by one cycle.
  always_comb begin
    latency_max_d = latency_max_q;
    if (clear_counters) begin
      latency_max_d = '0;
    end else if (latency_count > latency_max_q) begin
      latency_max_d = latency_count;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      latency_max_q <= '0;
    end else begin
      latency_max_q <= latency_max_d;
    end
  end

  assign latency_max = latency_max_q;

endmodule

// File: tb/tb_aurora_hls_nfc_ctrl.sv
// Self-checking bench for aurora_hls_nfc_ctrl. Two instances share stimulus:
//   u_dut_xoff  : XOFF/XON mode, no refresh, 32-bit counters
//   u_dut_timed : timed pause 16'h0040, refresh every 10 cycles, 4-bit counters
// A transaction-level model (offered request, paused flag, cycles since the
// last pause word) predicts every output after every clock edge.
module tb_aurora_hls_nfc_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic enable = 1'b1;
  logic clear_counters = 1'b0;
  logic fifo_full = 1'b0;
  logic fifo_empty = 1'b0;
  logic rx_tvalid = 1'b0;
  logic tready = 1'b1;

  always #5 clk = ~clk;

  logic        d0_tvalid, d1_tvalid;
  logic [15:0] d0_tdata, d1_tdata;
  logic [31:0] d0_full, d0_empty, d0_refr, d0_lat, d0_max;
  logic [3:0]  d1_full, d1_empty, d1_refr, d1_lat, d1_max;

  aurora_hls_nfc_ctrl #(
    .COUNT_WIDTH(32), .PAUSE_MODE(0), .PAUSE_VALUE(16'h00FF), .REFRESH_CYCLES(0)
  ) u_dut_xoff (
    .clk(clk), .rst(rst), .enable(enable), .clear_counters(clear_counters),
    .fifo_rx_prog_full(fifo_full), .fifo_rx_prog_empty(fifo_empty),
    .rx_tvalid(rx_tvalid), .s_axi_nfc_tready(tready),
    .s_axi_nfc_tvalid(d0_tvalid), .s_axi_nfc_tdata(d0_tdata),
    .full_trigger_count(d0_full), .empty_trigger_count(d0_empty),
    .refresh_count(d0_refr), .latency_count(d0_lat), .latency_max(d0_max)
  );

  aurora_hls_nfc_ctrl #(
    .COUNT_WIDTH(4), .PAUSE_MODE(1), .PAUSE_VALUE(16'h0040), .REFRESH_CYCLES(10)
  ) u_dut_timed (
    .clk(clk), .rst(rst), .enable(enable), .clear_counters(clear_counters),
    .fifo_rx_prog_full(fifo_full), .fifo_rx_prog_empty(fifo_empty),
    .rx_tvalid(rx_tvalid), .s_axi_nfc_tready(tready),
    .s_axi_nfc_tvalid(d1_tvalid), .s_axi_nfc_tdata(d1_tdata),
    .full_trigger_count(d1_full), .empty_trigger_count(d1_empty),
    .refresh_count(d1_refr), .latency_count(d1_lat), .latency_max(d1_max)
  );

  // Observed outputs, indexed [instance][field].
  localparam int NF = 7;
  logic [63:0] obs [2][NF];
  assign obs[0][0] = 64'(d0_tvalid);
  assign obs[0][1] = 64'(d0_tdata);
  assign obs[0][2] = 64'(d0_full);
  assign obs[0][3] = 64'(d0_empty);
  assign obs[0][4] = 64'(d0_refr);
  assign obs[0][5] = 64'(d0_lat);
  assign obs[0][6] = 64'(d0_max);
  assign obs[1][0] = 64'(d1_tvalid);
  assign obs[1][1] = 64'(d1_tdata);
  assign obs[1][2] = 64'(d1_full);
  assign obs[1][3] = 64'(d1_empty);
  assign obs[1][4] = 64'(d1_refr);
  assign obs[1][5] = 64'(d1_lat);
  assign obs[1][6] = 64'(d1_max);

  string field_name [NF] = '{"tvalid", "tdata", "full_cnt", "empty_cnt",
                             "refresh_cnt", "lat_cnt", "lat_max"};

  // Per-instance configuration as seen by the model.
  logic [15:0]     cfg_word    [2] = '{16'hFFFF, 16'h0040};
  int              cfg_refresh [2] = '{0, 10};
  longint unsigned cfg_max     [2] = '{64'hFFFF_FFFF, 64'hF};

  // Model state.
  typedef enum int {OFF_NONE, OFF_PAUSE, OFF_REFRESH, OFF_XON} offer_e;
  offer_e          m_offer  [2];
  bit              m_paused [2];
  int              m_idle   [2];
  logic [15:0]     m_word   [2];
  longint unsigned m_full [2], m_empty [2], m_refr [2], m_lat [2], m_max [2];

  int n_vectors = 0;
  int n_miscompares = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vectors++;
    if (got !== exp) begin
      n_miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic longint unsigned sat(input longint unsigned v, input int i);
    return (v < cfg_max[i]) ? v + 1 : v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_offer[i] = OFF_NONE; m_paused[i] = 1'b0; m_idle[i] = 0; m_word[i] = 16'h0000;
      m_full[i] = 0; m_empty[i] = 0; m_refr[i] = 0; m_lat[i] = 0; m_max[i] = 0;
    end
  endtask

  // One clock edge of the model, using the inputs present at that edge.
  task automatic model_update();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 2; i++) begin
      bit accepted;
      accepted = (m_offer[i] != OFF_NONE) && tready;
      // The high-water mark looks at the latency value before this edge.
      if (clear_counters) m_max[i] = 0;
      else if (m_lat[i] > m_max[i]) m_max[i] = m_lat[i];

      case (m_offer[i])
        OFF_NONE: begin
          if (!m_paused[i]) begin
            if (enable && fifo_full) begin
              m_offer[i] = OFF_PAUSE; m_word[i] = cfg_word[i];
            end
          end else begin
            if (rx_tvalid) m_lat[i] = sat(m_lat[i], i);
            if (fifo_empty || !enable) begin
              m_offer[i] = OFF_XON; m_word[i] = 16'h0000;
            end else begin
              m_idle[i]++;
              if (cfg_refresh[i] != 0 && m_idle[i] == cfg_refresh[i]) begin
                m_offer[i] = OFF_REFRESH; m_word[i] = cfg_word[i];
              end
            end
          end
        end
        OFF_PAUSE: if (accepted) begin
          m_full[i] = sat(m_full[i], i);
          m_lat[i] = 0; m_idle[i] = 0; m_paused[i] = 1'b1; m_offer[i] = OFF_NONE;
        end
        OFF_REFRESH: begin
          if (rx_tvalid) m_lat[i] = sat(m_lat[i], i);
          if (accepted) begin
            m_refr[i] = sat(m_refr[i], i); m_idle[i] = 0; m_offer[i] = OFF_NONE;
          end
        end
        OFF_XON: if (accepted) begin
          m_empty[i] = sat(m_empty[i], i); m_paused[i] = 1'b0; m_offer[i] = OFF_NONE;
        end
        default: ;
      endcase

      if (clear_counters) begin
        m_full[i] = 0; m_empty[i] = 0; m_refr[i] = 0; m_lat[i] = 0;
      end
    end
  endtask

  task automatic compare_all();
    logic [63:0] exp [NF];
    for (int i = 0; i < 2; i++) begin
      exp[0] = 64'(m_offer[i] != OFF_NONE);
      exp[1] = 64'(m_word[i]);
      exp[2] = m_full[i];
      exp[3] = m_empty[i];
      exp[4] = m_refr[i];
      exp[5] = m_lat[i];
      exp[6] = m_max[i];
      for (int f = 0; f < NF; f++)
        check($sformatf("d%0d.%s", i, field_name[f]), obs[i][f], exp[f]);
    end
  endtask

  // Inputs change 1 time unit after the edge and are stable at the next one.
  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    compare_all();
  endtask

  task automatic set_in(input bit full, input bit empty, input bit rx, input bit rdy);
    fifo_full = full; fifo_empty = empty; rx_tvalid = rx; tready = rdy;
  endtask

  initial begin
    model_reset();
    step();
    step();
    rst = 1'b0;

    // Basic XOFF with a stalled handshake; timed instance offers 0040.
    set_in(1, 0, 0, 0); step();
    check("d0.xoff_word", obs[0][1], 64'hFFFF);
    check("d1.timed_word", obs[1][1], 64'h0040);
    set_in(0, 0, 0, 0); step(); step();
    check("d0.held_tvalid", obs[0][0], 64'd1);
    set_in(0, 0, 0, 1); step();
    check("d0.full_after_accept", obs[0][2], 64'd1);

    // Latency episode one: 7 beats.
    for (int k = 0; k < 7; k++) begin set_in(0, 0, 1, 1); step(); end
    set_in(0, 1, 0, 1); step();
    check("d0.xon_word", obs[0][1], 64'h0000);
    set_in(0, 0, 0, 1); step();
    check("d0.lat_ep1", obs[0][5], 64'd7);
    check("d0.max_ep1", obs[0][6], 64'd7);
    check("d0.empty_after_xon", obs[0][3], 64'd1);

    // Latency episode two: 3 beats.
    set_in(1, 0, 0, 1); step();
    set_in(0, 0, 0, 1); step();
    for (int k = 0; k < 3; k++) begin set_in(0, 0, 1, 1); step(); end
    set_in(0, 1, 0, 1); step();
    set_in(0, 0, 0, 1); step();
    check("d0.lat_ep2", obs[0][5], 64'd3);
    check("d0.max_ep2", obs[0][6], 64'd7);

    // Refresh: 35 cycles paused after acceptance.
    set_in(1, 0, 0, 1); step();
    step();
    for (int k = 0; k < 35; k++) step();
    check("d1.refresh_35", obs[1][4], 64'd3);
    check("d0.refresh_none", obs[0][4], 64'd0);
    set_in(0, 1, 0, 1); step();
    set_in(0, 0, 0, 1); step();

    // XON and refresh due on the same cycle: XON wins.
    set_in(1, 0, 0, 1); step();
    set_in(0, 0, 0, 1); step();
    for (int k = 0; k < 9; k++) step();
    set_in(0, 1, 0, 1); step();
    check("d1.xon_over_refresh", obs[1][1], 64'h0000);
    check("d1.refresh_unchanged", obs[1][4], 64'd3);
    set_in(0, 0, 0, 1); step();

    // enable low in RUN ignores prog_full; dropping enable while paused sends XON.
    enable = 1'b0;
    set_in(1, 0, 0, 1);
    for (int k = 0; k < 5; k++) step();
    check("d0.disabled_no_req", obs[0][0], 64'd0);
    enable = 1'b1; step();
    set_in(0, 0, 0, 1); step();
    enable = 1'b0; step();
    check("d0.disable_xon_valid", obs[0][0], 64'd1);
    check("d0.disable_xon_word", obs[0][1], 64'h0000);
    step();
    enable = 1'b1;

    // Clear together with an accepting handshake.
    set_in(1, 0, 0, 0); step();
    set_in(0, 0, 0, 1); clear_counters = 1'b1; step();
    clear_counters = 1'b0;
    check("d0.clear_wins", obs[0][2], 64'd0);
    set_in(0, 1, 0, 1); step();
    set_in(0, 0, 0, 1); step();

    // 20 pause/XON rounds: the 4-bit instance saturates.
    for (int k = 0; k < 20; k++) begin
      set_in(1, 0, 0, 1); step();
      set_in(0, 0, 0, 1); step();
      set_in(0, 1, 0, 1); step();
      set_in(0, 0, 0, 1); step();
    end
    check("d1.full_saturated", obs[1][2], 64'd15);
    check("d0.full_20", obs[0][2], 64'd20);

    // Randomized traffic.
    for (int k = 0; k < 2500; k++) begin
      fifo_full      = ($urandom_range(0, 3) == 0);
      fifo_empty     = ($urandom_range(0, 7) == 0);
      rx_tvalid      = $urandom_range(0, 1) == 1;
      tready         = ($urandom_range(0, 3) != 0);
      enable         = ($urandom_range(0, 15) != 0);
      clear_counters = ($urandom_range(0, 63) == 0);
      step();
    end
    clear_counters = 1'b0;

    // Drain to idle, then reset while a request is on the wire.
    enable = 1'b0; set_in(0, 0, 0, 1);
    for (int k = 0; k < 6; k++) step();
    enable = 1'b1; set_in(1, 0, 0, 0);
    step();
    check("d0.tvalid_before_rst", obs[0][0], 64'd1);
    rst = 1'b1;
    #1;
    model_reset();
    check("d0.tvalid_async_rst", obs[0][0], 64'd0);
    check("d1.tvalid_async_rst", obs[1][0], 64'd0);
    compare_all();
    step();
    rst = 1'b0;
    set_in(0, 0, 0, 1);
    step();

    $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
    $finish;
  end

endmodule

// File: doc/aurora_hls_nfc_ctrl.md
Name: aurora_hls_nfc_ctrl

Overview:
- Parametrised native-flow-control (NFC) controller for the Aurora RX path. It watches the RX FIFO prog_full/prog_empty flags and issues XOFF or timed-pause requests on the core's s_axi_nfc AXI-Stream port. XON is issued with hysteresis once the FIFO drains.
- New relative to the previous generation: periodic pause refresh, a selectable timed-pause mode, an enable gate, saturating counters, a software counter clear, and max-latency capture.

Parameters:
- COUNT_WIDTH, 32: width of all statistics counters.
- PAUSE_MODE, 0: 0 = XOFF/XON (XOFF word 16'hFFFF); 1 = timed pause (word = PAUSE_VALUE).
- PAUSE_VALUE, 16'h00FF: pause word used when PAUSE_MODE=1; must be nonzero and not 16'hFFFF.
- REFRESH_CYCLES, 0: while paused, re-send the pause word every REFRESH_CYCLES cycles; 0 = disabled. Must be nonzero when PAUSE_MODE=1.

Ports:
- clk  in  1  single clock domain.
- rst  in  1  asynchronous, active-high reset.
- enable  in  1  permits new pause requests.
- clear_counters  in  1  synchronous clear of all statistics.
- fifo_rx_prog_full  in  1  RX FIFO above high threshold.
- fifo_rx_prog_empty  in  1  RX FIFO below low threshold.
- rx_tvalid  in  1  RX data beat arriving from the core.
- s_axi_nfc_tready  in  1  NFC handshake ready.
- s_axi_nfc_tvalid  out  1  NFC request valid.
- s_axi_nfc_tdata  out  16 ([0:15], big endian)  NFC word.
- full_trigger_count  out  COUNT_WIDTH  initial pause requests accepted.
- empty_trigger_count  out  COUNT_WIDTH  XON requests accepted.
- refresh_count  out  COUNT_WIDTH  refresh pause requests accepted.
- latency_count  out  COUNT_WIDTH  rx beats received since the current/last pause was accepted.
- latency_max  out  COUNT_WIDTH  maximum latency_count observed.

Behaviour:
- Reset (async assert, sync deassert handled externally): state RUN, tvalid=0, tdata=16'h0000, all counters 0, refresh timer 0.
- FSM states: RUN, SEND_PAUSE, PAUSED, SEND_REFRESH, SEND_XON. All outputs are registered.
- RUN → SEND_PAUSE when enable && prog_full. tvalid=1 and tdata=pause word appear the next cycle. prog_full has priority if both flags are high.
- SEND_PAUSE:
  - tvalid and tdata are held stable until tvalid&&tready; no retraction, even if prog_full drops or enable falls.
  - On the handshake cycle: tvalid←0, full_trigger_count+1, latency_count←0, refresh timer←0, → PAUSED.
- PAUSED:
  - rx_tvalid increments latency_count.
  - If prog_empty || !enable → SEND_XON, with tdata=16'h0000.
  - Else if REFRESH_CYCLES≠0 and the timer reaches REFRESH_CYCLES-1 → SEND_REFRESH.
  - Otherwise the timer increments.
  - XON takes priority over refresh on the same cycle.
- SEND_REFRESH:
  - Same pause word; rx_tvalid still counts into latency_count.
  - On handshake: refresh_count+1, timer←0, → PAUSED. latency_count is not cleared.
- SEND_XON: on handshake, empty_trigger_count+1 → RUN.
- Back-to-back: a RUN cycle with prog_full still high re-enters SEND_PAUSE on the next cycle (minimum one RUN cycle between XON and the next pause).
- enable low in RUN: no requests issued; the flags are ignored.
- latency_max ← latency_count whenever latency_count > latency_max (registered, one-cycle lag).
- Counters saturate at all-ones; no wrap.
- clear_counters: all five counters ← 0 on the next edge. It does not affect the FSM, tvalid or tdata. A clear takes priority over a same-cycle increment.
- Reset mid-handshake: tvalid drops immediately (async); the FSM returns to RUN.

Decomposition:
- Shared package aurora_hls_nfc_pkg holds:
  - state encoding localparams;
  - NFC_XOFF=16'hFFFF and NFC_XON=16'h0000;
  - a saturating-increment function.
- One sub-module: aurora_hls_sat_counter (COUNT_WIDTH, inc, clr), instantiated five times. latency_max is kept local.

Test Plan:
- Basic XOFF/XON, REFRESH_CYCLES=0: raise prog_full; tready=0 for 3 cycles then 1 → tvalid stays high with tdata=FFFF for 4 cycles, full_trigger_count=1. Then pulse prog_empty → XON tdata=0000, empty_trigger_count=1, state RUN.
- Latency capture: pause accepted, then 7 rx_tvalid beats before XON → latency_count=7, latency_max=7. A second episode with 3 beats → latency_count=3, latency_max=7.
- Refresh, REFRESH_CYCLES=10, tready=1: hold prog_full for 35 cycles after the pause is accepted → refresh_count=3, each refresh spaced 11 cycles (10 timer + 1 handshake). Assert prog_empty on the same cycle the timer expires → XON is sent, not a refresh.
- Timed mode, PAUSE_MODE=1, PAUSE_VALUE=16'h0040: prog_full → tdata=0040. Release → tdata=0000.
- Enable/clear:
  - enable=0 with prog_full high → no tvalid.
  - Drop enable while PAUSED → XON is issued.
  - clear_counters together with an accepting handshake → counter reads 0.
- Saturation and reset: COUNT_WIDTH=4, 20 pause/XON cycles → full_trigger_count=15. Assert rst while tvalid=1 → tvalid=0 in the same cycle and all counters=0.
